// File: rtl/player_controller.sv
// player_controller: per-frame camera update for the raycaster.
// Rotates through a 64-step angle table, then moves with per-axis wall checks.
module player_controller #(
   parameter int          MAP_SIZE    = 24,
   parameter logic [15:0] MOVE_SPEED  = 16'h0010,
   parameter int          MAP_LATENCY = 2,
   parameter logic [15:0] START_X     = 16'h0B80,
   parameter logic [15:0] START_Y     = 16'h0B80,
   parameter int          START_ANGLE = 0
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   input  logic        new_frame_in,
   input  logic        moveFwd,
   input  logic        moveBack,
   input  logic        rotLeft,
   input  logic        rotRight,
   output logic [9:0]  map_addr_out,
   input  logic [3:0]  map_data_in,
   output logic [15:0] posX,
   output logic [15:0] posY,
   output logic [15:0] dirX,
   output logic [15:0] dirY,
   output logic [15:0] planeX,
   output logic [15:0] planeY,
   output logic        busy_out,
   output logic        valid_out
);

   typedef enum logic [2:0] {
      IDLE, ROT, MOVE, REQX, WAITX, REQY, WAITY, COMMIT
   } state_t;

   localparam int CW = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY) : 1;

   // cos(k*5.625deg)*256, first quadrant
   function automatic logic [15:0] cq(input logic [4:0] k);
      logic [15:0] v;
      case (k)
         5'd0:    v = 16'd256;
         5'd1:    v = 16'd255;
         5'd2:    v = 16'd251;
         5'd3:    v = 16'd245;
         5'd4:    v = 16'd237;
         5'd5:    v = 16'd226;
         5'd6:    v = 16'd213;
         5'd7:    v = 16'd198;
         5'd8:    v = 16'd181;
         5'd9:    v = 16'd162;
         5'd10:   v = 16'd142;
         5'd11:   v = 16'd121;
         5'd12:   v = 16'd98;
         5'd13:   v = 16'd74;
         5'd14:   v = 16'd50;
         5'd15:   v = 16'd25;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   // cos(k*5.625deg)*0.66*256, first quadrant
   function automatic logic [15:0] pq(input logic [4:0] k);
      logic [15:0] v;
      case (k)
         5'd0:    v = 16'd169;
         5'd1:    v = 16'd168;
         5'd2:    v = 16'd166;
         5'd3:    v = 16'd162;
         5'd4:    v = 16'd156;
         5'd5:    v = 16'd149;
         5'd6:    v = 16'd140;
         5'd7:    v = 16'd131;
         5'd8:    v = 16'd119;
         5'd9:    v = 16'd107;
         5'd10:   v = 16'd94;
         5'd11:   v = 16'd80;
         5'd12:   v = 16'd65;
         5'd13:   v = 16'd49;
         5'd14:   v = 16'd33;
         5'd15:   v = 16'd17;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   // Full circle by quadrant symmetry: {dirX, dirY, planeX, planeY}
   function automatic logic [63:0] lut(input logic [5:0] a);
      logic [4:0]  kc, ks;
      logic [15:0] c, s, pc, ps, npx;
      kc = {1'b0, a[3:0]};
      ks = 5'd16 - kc;
      case (a[5:4])
         2'd0: begin
            c = cq(kc);  s = cq(ks);
            pc = pq(kc); ps = pq(ks);
         end
         2'd1: begin
            c = -cq(ks);  s = cq(kc);
            pc = -pq(ks); ps = pq(kc);
         end
         2'd2: begin
            c = -cq(kc);  s = -cq(ks);
            pc = -pq(kc); ps = -pq(ks);
         end
         default: begin
            c = cq(ks);  s = -cq(kc);
            pc = pq(ks); ps = -pq(kc);
         end
      endcase
      npx = -ps;
      return {c, s, npx, pc};
   endfunction

   // Signed per-frame displacement along one dir component
   function automatic logic signed [16:0] step(input logic [15:0] d);
      logic signed [31:0] p;
      p = $signed({{16{d[15]}}, d}) * $signed({16'd0, MOVE_SPEED});
      return 17'(p >>> 8);
   endfunction

   function automatic logic oob(input logic signed [16:0] c);
      return c[16] || (int'(c[15:8]) >= MAP_SIZE);
   endfunction

   function automatic logic [9:0] maddr(input logic [7:0] cy, input logic [7:0] cx);
      return 10'(int'(cy) * MAP_SIZE + int'(cx));
   endfunction

   localparam logic [63:0] INIT = lut(6'(START_ANGLE));

   state_t             state, state_n;
   logic [3:0]         btn;
   logic [5:0]         ang, ang_w, ang_n;
   logic [15:0]        dx_w, dy_w, px_w, py_w;
   logic [15:0]        cand_x, cand_y;
   logic signed [16:0] cx_n, cy_n, base_x, base_y, del_x, del_y;
   logic               oob_x, oob_y, block_x;
   logic [CW-1:0]      wcnt;
   logic               wait_done;

   assign wait_done = (wcnt == CW'(MAP_LATENCY - 1));

   // State register
   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_n;
   end

   // Sequencing plus busy/valid flags
   always_comb begin
      state_n   = state;
      busy_out  = 1'b1;
      valid_out = 1'b0;
      unique case (state)
         IDLE: begin
            busy_out = 1'b0;
            if (new_frame_in) state_n = ROT;
         end
         ROT:   state_n = MOVE;
         MOVE:  state_n = REQX;
         REQX:  state_n = WAITX;
         WAITX: if (wait_done) state_n = REQY;
         REQY:  state_n = WAITY;
         WAITY: if (wait_done) state_n = COMMIT;
         COMMIT: begin
            busy_out  = 1'b0;
            valid_out = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Next angle and candidate positions from the latched buttons
   always_comb begin
      ang_n  = ang;
      unique case (btn[1:0])
         2'b10:   ang_n = ang + 6'd1;
         2'b01:   ang_n = ang - 6'd1;
         default: ang_n = ang;
      endcase
      del_x  = step(dx_w);
      del_y  = step(dy_w);
      base_x = $signed({1'b0, posX});
      base_y = $signed({1'b0, posY});
      cx_n   = base_x;
      cy_n   = base_y;
      unique case (btn[3:2])
         2'b10: begin
            cx_n = base_x + del_x;
            cy_n = base_y + del_y;
         end
         2'b01: begin
            cx_n = base_x - del_x;
            cy_n = base_y - del_y;
         end
         default: begin
            cx_n = base_x;
            cy_n = base_y;
         end
      endcase
   end

   // Working registers, map requests, and the committed camera state
   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         btn          <= 4'd0;
         ang          <= 6'(START_ANGLE);
         ang_w        <= 6'(START_ANGLE);
         {dx_w, dy_w, px_w, py_w}       <= INIT;
         {dirX, dirY, planeX, planeY}   <= INIT;
         posX         <= START_X;
         posY         <= START_Y;
         cand_x       <= 16'd0;
         cand_y       <= 16'd0;
         oob_x        <= 1'b0;
         oob_y        <= 1'b0;
         block_x      <= 1'b0;
         wcnt         <= '0;
         map_addr_out <= 10'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (new_frame_in)
                  btn <= {moveFwd, moveBack, rotLeft, rotRight};
            end
            ROT: begin
               ang_w                    <= ang_n;
               {dx_w, dy_w, px_w, py_w} <= lut(ang_n);
            end
            MOVE: begin
               cand_x       <= cx_n[15:0];
               cand_y       <= cy_n[15:0];
               oob_x        <= oob(cx_n);
               oob_y        <= oob(cy_n);
               map_addr_out <= oob(cx_n) ? 10'd0
                               : maddr(posY[15:8], cx_n[15:8]);
            end
            REQX: wcnt <= '0;
            WAITX: begin
               wcnt <= wcnt + 1'b1;
               if (wait_done) begin
                  block_x      <= oob_x || (map_data_in != 4'd0);
                  map_addr_out <= oob_y ? 10'd0
                                  : maddr(cand_y[15:8], posX[15:8]);
               end
            end
            REQY: wcnt <= '0;
            WAITY: begin
               wcnt <= wcnt + 1'b1;
               if (wait_done) begin
                  if (!block_x) posX <= cand_x;
                  if (!(oob_y || (map_data_in != 4'd0))) posY <= cand_y;
                  {dirX, dirY, planeX, planeY} <= {dx_w, dy_w, px_w, py_w};
                  ang <= ang_w;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_player_controller.sv
// tb_player_controller: vector table, corner sequences and randomized frames
// checked against a trigonometric reference model of the camera update.
module tb_player_controller;

   logic        pixel_clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        new_frame_in = 1'b0;
   logic        moveFwd = 1'b0, moveBack = 1'b0;
   logic        rotLeft = 1'b0, rotRight = 1'b0;
   logic [9:0]  map_addr_out;
   logic [3:0]  map_data_in;
   logic [15:0] posX, posY, dirX, dirY, planeX, planeY;
   logic        busy_out, valid_out;

   player_controller dut (
      .pixel_clk_in(pixel_clk_in), .rst_in(rst_in),
      .new_frame_in(new_frame_in),
      .moveFwd(moveFwd), .moveBack(moveBack),
      .rotLeft(rotLeft), .rotRight(rotRight),
      .map_addr_out(map_addr_out), .map_data_in(map_data_in),
      .posX(posX), .posY(posY), .dirX(dirX), .dirY(dirY),
      .planeX(planeX), .planeY(planeY),
      .busy_out(busy_out), .valid_out(valid_out)
   );

   always #5 pixel_clk_in = ~pixel_clk_in;

   // Map ROM with two cycles from address to data
   logic [3:0] map_mem [0:575];
   logic [3:0] d1 = 4'd0, d2 = 4'd0;
   always @(posedge pixel_clk_in) begin
      d1 <= (map_addr_out < 10'd576) ? map_mem[map_addr_out] : 4'd0;
      d2 <= d1;
   end
   assign map_data_in = d2;

   int checks = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   int m_px, m_py, m_ang;

   function automatic int rnd(input real r);
      if (r >= 0.0) return $rtoi(r + 0.5);
      return -$rtoi(0.5 - r);
   endfunction

   function automatic int tbl(input int sel, input int a);
      real th, r;
      th = a * 5.625 * 3.141592653589793 / 180.0;
      case (sel)
         0:       r = 256.0 * $cos(th);
         1:       r = 256.0 * $sin(th);
         2:       r = -0.66 * 256.0 * $sin(th);
         default: r = 0.66 * 256.0 * $cos(th);
      endcase
      return rnd(r);
   endfunction

   function automatic bit blocked(input int c, input int other, input bit is_x);
      if (c < 0 || c / 256 >= 24) return 1'b1;
      if (is_x) return map_mem[(other / 256) * 24 + c / 256] != 4'd0;
      return map_mem[(c / 256) * 24 + other / 256] != 4'd0;
   endfunction

   task automatic model_reset();
      m_px = 'h0B80;
      m_py = 'h0B80;
      m_ang = 0;
   endtask

   task automatic model_frame(input bit f, input bit b, input bit l, input bit r);
      int dx, dy, mv, cx, cy;
      bit bx, by;
      if (l && !r) m_ang = (m_ang + 1) % 64;
      else if (r && !l) m_ang = (m_ang + 63) % 64;
      dx = tbl(0, m_ang);
      dy = tbl(1, m_ang);
      mv = (f && !b) ? 1 : ((b && !f) ? -1 : 0);
      cx = m_px + mv * $rtoi($floor(dx * 16.0 / 256.0));
      cy = m_py + mv * $rtoi($floor(dy * 16.0 / 256.0));
      bx = blocked(cx, m_py, 1'b1);
      by = blocked(cy, m_px, 1'b0);
      if (!bx) m_px = cx;
      if (!by) m_py = cy;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_posX"}, posX, 16'(m_px));
      chk({tag, "_posY"}, posY, 16'(m_py));
      chk({tag, "_dirX"}, dirX, 16'(tbl(0, m_ang)));
      chk({tag, "_dirY"}, dirY, 16'(tbl(1, m_ang)));
      chk({tag, "_planeX"}, planeX, 16'(tbl(2, m_ang)));
      chk({tag, "_planeY"}, planeY, 16'(tbl(3, m_ang)));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_posX"}, posX, 16'h0B80);
      chk({tag, "_posY"}, posY, 16'h0B80);
      chk({tag, "_dirX"}, dirX, 16'h0100);
      chk({tag, "_dirY"}, dirY, 16'h0000);
      chk({tag, "_planeX"}, planeX, 16'h0000);
      chk({tag, "_planeY"}, planeY, 16'h00A9);
      chk({tag, "_valid"}, 16'(valid_out), 16'd0);
      chk({tag, "_busy"}, 16'(busy_out), 16'd0);
      chk({tag, "_addr"}, 16'(map_addr_out), 16'd0);
   endtask

   task automatic do_reset();
      @(negedge pixel_clk_in);
      rst_in = 1'b0;
      repeat (2) @(negedge pixel_clk_in);
      rst_in = 1'b1;
      @(negedge pixel_clk_in);
      model_reset();
   endtask

   // One frame: pulse, scramble buttons after latch, time the valid pulse
   task automatic run_frame(input bit f, input bit b, input bit l, input bit r);
      int lat;
      {moveFwd, moveBack, rotLeft, rotRight} = {f, b, l, r};
      new_frame_in = 1'b1;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge pixel_clk_in);
         if (i == 1) begin
            new_frame_in = 1'b0;
            chk("busy_rise", 16'(busy_out), 16'd1);
            {moveFwd, moveBack, rotLeft, rotRight} = 4'($urandom);
         end
         if (valid_out) begin
            lat = i;
            break;
         end
      end
      chk("latency", 16'(lat), 16'd9);
      if (lat != 0) begin
         @(negedge pixel_clk_in);
         chk("valid_one_cycle", 16'(valid_out), 16'd0);
         chk("busy_fall", 16'(busy_out), 16'd0);
      end
      model_frame(f, b, l, r);
   endtask

   typedef struct {
      logic [3:0]  btn;
      logic [15:0] px, py, dx, dy, plx, ply;
   } vec_t;

   vec_t vecs [8];
   int npulse;

   initial begin
      vecs[0] = '{4'b1000, 16'h0B90, 16'h0B80, 16'h0100, 16'h0000, 16'h0000, 16'h00A9};
      vecs[1] = '{4'b0010, 16'h0B90, 16'h0B80, 16'h00FF, 16'h0019, 16'hFFEF, 16'h00A8};
      vecs[2] = '{4'b0001, 16'h0B90, 16'h0B80, 16'h0100, 16'h0000, 16'h0000, 16'h00A9};
      vecs[3] = '{4'b1111, 16'h0B90, 16'h0B80, 16'h0100, 16'h0000, 16'h0000, 16'h00A9};
      vecs[4] = '{4'b0000, 16'h0B90, 16'h0B80, 16'h0100, 16'h0000, 16'h0000, 16'h00A9};
      vecs[5] = '{4'b0100, 16'h0B80, 16'h0B80, 16'h0100, 16'h0000, 16'h0000, 16'h00A9};
      vecs[6] = '{4'b1010, 16'h0B8F, 16'h0B81, 16'h00FF, 16'h0019, 16'hFFEF, 16'h00A8};
      vecs[7] = '{4'b0101, 16'h0B7F, 16'h0B81, 16'h0100, 16'h0000, 16'h0000, 16'h00A9};

      for (int i = 0; i < 576; i++) map_mem[i] = 4'd0;
      model_reset();

      repeat (3) @(negedge pixel_clk_in);
      chk_reset("rst_held");
      rst_in = 1'b1;
      @(negedge pixel_clk_in);
      chk_reset("rst_release");

      // Vector table on an empty map
      for (int v = 0; v < 8; v++) begin
         run_frame(vecs[v].btn[3], vecs[v].btn[2], vecs[v].btn[1], vecs[v].btn[0]);
         chk($sformatf("vec%0d_posX", v), posX, vecs[v].px);
         chk($sformatf("vec%0d_posY", v), posY, vecs[v].py);
         chk($sformatf("vec%0d_dirX", v), dirX, vecs[v].dx);
         chk($sformatf("vec%0d_dirY", v), dirY, vecs[v].dy);
         chk($sformatf("vec%0d_planeX", v), planeX, vecs[v].plx);
         chk($sformatf("vec%0d_planeY", v), planeY, vecs[v].ply);
      end

      // Second frame pulse while busy is dropped
      {moveFwd, moveBack, rotLeft, rotRight} = 4'b1000;
      new_frame_in = 1'b1;
      npulse = 0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge pixel_clk_in);
         if (i == 1) new_frame_in = 1'b0;
         if (i == 3) new_frame_in = 1'b1;
         if (i == 4) new_frame_in = 1'b0;
         if (valid_out) npulse++;
      end
      chk("single_pulse", 16'(npulse), 16'd1);
      model_frame(1'b1, 1'b0, 1'b0, 1'b0);
      chk_model("double_nf");

      // Reset while waiting on the X map read
      {moveFwd, moveBack, rotLeft, rotRight} = 4'b1000;
      new_frame_in = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge pixel_clk_in);
         if (i == 1) new_frame_in = 1'b0;
      end
      rst_in = 1'b0;
      #1;
      chk_reset("rst_async");
      npulse = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge pixel_clk_in);
         if (i == 4) rst_in = 1'b1;
         if (valid_out) npulse++;
      end
      chk("no_pulse_after_rst", 16'(npulse), 16'd0);
      model_reset();
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_posX", posX, 16'h0B90);
      chk_model("post_rst");

      // Wall at cell (12, 11)
      do_reset();
      map_mem[11 * 24 + 12] = 4'd3;
      for (int f = 0; f < 10; f++) begin
         run_frame(1'b1, 1'b0, 1'b0, 1'b0);
         chk_model($sformatf("wall%0d", f));
      end
      chk("wall_final_posX", posX, 16'h0BF0);
      chk("wall_final_posY", posY, 16'h0B80);
      map_mem[11 * 24 + 12] = 4'd0;

      // Walk to both map edges
      do_reset();
      for (int f = 0; f < 200; f++) begin
         run_frame(1'b0, 1'b1, 1'b0, 1'b0);
         chk_model("edge_lo");
      end
      chk("edge_lo_posX", posX, 16'h0000);
      for (int f = 0; f < 400; f++) begin
         run_frame(1'b1, 1'b0, 1'b0, 1'b0);
         chk_model("edge_hi");
      end
      chk("edge_hi_posX", posX, 16'h17F0);

      // Randomized walls and buttons
      do_reset();
      for (int i = 0; i < 576; i++)
         map_mem[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      map_mem[11 * 24 + 11] = 4'd0;
      for (int f = 0; f < 80; f++) begin
         run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         chk_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/player_controller.md
Name: player_controller

Overview:
- Upstream stage of ray_calculations. It replaces the constant posX/posY/dirX/dirY/planeX/planeY assignments in the top level.
- Once per video frame it samples the four debounced buttons. It rotates the view through a 64-entry angle table, then moves the player along dir with a per-axis wall-collision check against the map ROM.
- It publishes a consistent camera state with a one-cycle valid pulse.

Parameters:
- MAP_SIZE, 24: map is MAP_SIZE x MAP_SIZE cells; map address = cellY*MAP_SIZE + cellX.
- MOVE_SPEED, 16'h0010: unsigned 8.8 step length per frame (1/16 cell).
- MAP_LATENCY, 2: cycles from map_addr_out to valid map_data_in.
- START_X, 16'h0B80: reset posX, 8.8.
- START_Y, 16'h0B80: reset posY, 8.8.
- START_ANGLE, 0: reset angle index, 0..63.

Ports:
- pixel_clk_in  in  1  system clock (clk_pixel, 74.25 MHz).
- rst_in  in  1  asynchronous, active-low reset.
- new_frame_in  in  1  one-cycle frame pulse (nf_out of video_sig_gen).
- moveFwd  in  1  debounced level.
- moveBack  in  1  debounced level.
- rotLeft  in  1  debounced level.
- rotRight  in  1  debounced level.
- map_addr_out  out  10  map ROM address.
- map_data_in  in  4  map cell type; 0 = empty.
- posX, posY  out  16  unsigned 8.8 position.
- dirX, dirY  out  16  signed 8.8 direction.
- planeX, planeY  out  16  signed 8.8 camera plane.
- busy_out  out  1  high while an update is in progress.
- valid_out  out  1  one-cycle pulse when new state is committed.

Behaviour:
- Reset (async assert, sync release):
  - posX = START_X, posY = START_Y, angle = START_ANGLE.
  - dir/plane loaded from table[START_ANGLE]; for angle 0: dirX = 0x0100, dirY = 0, planeX = 0, planeY = 0x00A9.
  - map_addr_out = 0, busy_out = 0, valid_out = 0, FSM = IDLE.
- Angle table: 64 entries, angle a = a*5.625 deg, all values rounded to nearest:
  - dirX = cos(a)*256, dirY = sin(a)*256.
  - planeX = -sin(a)*0.66*256, planeY = cos(a)*0.66*256.
- FSM sequence: IDLE -> ROT -> MOVE -> REQX -> WAITX -> REQY -> WAITY -> COMMIT -> IDLE.
  - IDLE: on new_frame_in, latch the four buttons and go to ROT; busy_out goes high next cycle.
  - ROT: rotLeft only: angle = angle+1 mod 64. rotRight only: angle = angle-1 mod 64. Both or neither: unchanged. The table lookup of the new angle is registered into working dir/plane.
  - MOVE: delta = (working dir * MOVE_SPEED) >>> 8, 32-bit signed product, arithmetic shift.
    - moveFwd only: candidate = pos + delta.
    - moveBack only: candidate = pos - delta.
    - Both or neither: candidate = pos.
    - Candidates are 17-bit signed.
  - REQX: map_addr_out = candY_old_cell*MAP_SIZE + candX_cell, where Y uses the old posY integer part.
  - WAITX: hold MAP_LATENCY cycles, then sample blockX = (map_data_in != 0).
  - REQY: address uses the old posX integer part and candidate Y.
  - WAITY: hold MAP_LATENCY cycles, then sample blockY.
  - Out-of-range candidate (negative, or integer part >= MAP_SIZE) is treated as a wall; no map read is needed, but the state timing is unchanged.
  - COMMIT: posX = blockX ? posX : candX; posY = blockY ? posY : candY. dir/plane/angle take working values. valid_out = 1 for this cycle only. busy_out drops. Return to IDLE.
- Outputs change only in COMMIT, so they stay stable between valid pulses.
- Fixed latency: valid_out is high 2*MAP_LATENCY+5 cycles after the cycle new_frame_in is sampled (9 cycles at default). A valid pulse occurs every frame, even with no button pressed.
- new_frame_in while busy: ignored, no queueing.
- Button changes after latch: ignored until the next frame.
- Reset mid-operation: all state returns to reset values immediately; no valid pulse; a pending update is discarded.

Test Plan:
- Reset, empty map -> posX = posY = 0x0B80, dirX = 0x0100, dirY = 0, planeX = 0, planeY = 0x00A9; valid_out = 0, busy_out = 0.
- moveFwd held, new_frame pulse, empty map -> valid_out 9 cycles later; posX = 0x0B90, posY = 0x0B80.
- Wall at cell (x = 12, y = 11), moveFwd held for 10 frames -> posX climbs to 0x0BF0, then stays at 0x0BF0 (candidate 0x0C00 is blocked); posY = 0x0B80 throughout.
- rotLeft for one frame from angle 0 -> dirX = 0x00FF, dirY = 0x0019, planeX = 0xFFEF, planeY = 0x00A8. Then rotRight for one frame -> reset dir/plane values exactly.
- moveFwd + moveBack + rotLeft + rotRight all high -> state unchanged, valid_out still pulses. A second new_frame_in 3 cycles after the first -> only one valid pulse.
- rst_in low during WAITX -> outputs return to reset values asynchronously; no valid pulse; next new_frame after release completes normally in 9 cycles.
